// File: rtl/gpu_pkg.sv
// Shared definitions for the PC / branch-resolution stage.
//   pc_state_t : sequencing states of pc_branch_ctrl
//   PC_W       : program counter width
//   NZP_*      : bit positions inside the {n,z,p} mask and {lt,eq,gt} flags
//   nzp_match  : branch condition test (mask AND flags, any bit set)
package gpu_pkg;

  localparam int PC_W  = 8;
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pc_state_t;

  function automatic logic nzp_match(input logic [2:0] mask, input logic [2:0] flags);
    return (mask[NZP_N] & flags[NZP_N]) |
           (mask[NZP_Z] & flags[NZP_Z]) |
           (mask[NZP_P] & flags[NZP_P]);
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_flush_ctr.sv
// 3-bit load/decrement counter timing the post-branch flush window.
// Ports:
//   clk, reset     : clock, async active-high reset
//   i_load         : load i_load_val (wins over decrement)
//   i_dec          : decrement by one, stops at zero
//   i_load_val     : value to load
//   o_last         : counter currently reads 1 (final flush cycle)
module flush_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic [2:0] i_load_val,
  output logic       o_last
);

  logic [2:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 3'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign o_last = (r_count == 3'd1);

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution stage.
// Holds the fetch PC, advances it under the fetch handshake, resolves BRnzp
// against the registered NZP flags, redirects and flushes on a taken branch,
// sequences kernel start/halt and counts taken branches (saturating).
// Ports:
//   clk, reset       : clock, async active-high reset
//   start            : launch pulse (honoured in IDLE and DONE only)
//   stall            : freeze PC, defer branch/halt evaluation
//   fetch_ready      : fetch accepted the PC this cycle
//   branch_en        : BRnzp in this stage
//   branch_nzp       : condition mask {n,z,p}
//   nzp_val          : flags {lt,eq,gt}
//   nab_out2         : branch target
//   halt             : halt instruction in this stage
//   pc, fetch_valid, flush, taken, done, taken_count : registered/decoded outputs
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start, PC parked at START_PC
// ST_RUN   | fetching; evaluates halt > taken branch > increment
// ST_FLUSH | squashing wrong-path work for FLUSH_CYCLES cycles
// ST_DONE  | kernel halted, waiting for start
module pc_branch_ctrl
  import gpu_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC     = 8'h00,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            branch_en,
  input  logic [2:0]      branch_nzp,
  input  logic [2:0]      nzp_val,
  input  logic [PC_W-1:0] nab_out2,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            taken,
  output logic            done,
  output logic [7:0]      taken_count
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            r_taken;
  logic            w_taken_nxt;
  logic [7:0]      r_taken_count;
  logic            w_count_inc;
  logic            w_flush_load;
  logic            w_flush_dec;
  logic            w_flush_last;
  logic            w_branch_hit;

  assign w_branch_hit = branch_en && nzp_match(branch_nzp, nzp_val);

  flush_ctr u_flush_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_flush_load),
    .i_dec      (w_flush_dec),
    .i_load_val (FLUSH_LOAD),
    .o_last     (w_flush_last)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_taken_nxt  = 1'b0;
    w_count_inc  = 1'b0;
    w_flush_load = 1'b0;
    w_flush_dec  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_PC;
        end
      end
      ST_RUN: begin
        // A stalled cycle evaluates nothing; the held instruction is seen
        // once, on the first cycle stall is low.
        if (!stall) begin
          if (halt) begin
            w_state_nxt = ST_DONE;
          end else if (w_branch_hit) begin
            w_state_nxt  = ST_FLUSH;
            w_pc_nxt     = nab_out2;
            w_taken_nxt  = 1'b1;
            w_count_inc  = 1'b1;
            w_flush_load = 1'b1;
          end else if (fetch_ready) begin
            w_pc_nxt = r_pc + 8'd1;
          end
        end
      end
      ST_FLUSH: begin
        w_flush_dec = 1'b1;
        if (w_flush_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_PC;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = START_PC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= START_PC;
      r_taken       <= 1'b0;
      r_taken_count <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_taken <= w_taken_nxt;
      if (w_count_inc && (r_taken_count != 8'hFF)) begin
        r_taken_count <= r_taken_count + 8'd1;
      end
    end
  end

  assign pc          = r_pc;
  assign fetch_valid = (r_state == ST_RUN);
  assign flush       = (r_state == ST_FLUSH);
  assign done        = (r_state == ST_DONE);
  assign taken       = r_taken;
  assign taken_count = r_taken_count;

endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter and branch-resolution stage that sits directly downstream of the NZP/next-address block. Holds the fetch PC, advances it sequentially under a fetch handshake, and on a BRnzp instruction tests the branch mask against the registered NZP flags. A taken branch redirects to the 8-bit target and squashes wrong-path instructions with a timed flush. Also sequences kernel start/halt and keeps a saturating taken-branch counter.

## Interface
Parameters:
- `START_PC`, default 8'h00: PC loaded on reset and on start.
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high after a taken branch; legal range 1..7.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: pulse; launches execution from IDLE or DONE.
- `stall` in 1: hazard stall; freezes PC and blocks branch/halt evaluation.
- `fetch_ready` in 1: fetch stage accepts the PC this cycle.
- `branch_en` in 1: instruction in this stage is BRnzp.
- `branch_nzp` in 3: condition mask {n,z,p}.
- `nzp_val` in 3: registered flags {lt,eq,gt} from the compare block.
- `nab_out2` in 8: branch target (immediate).
- `halt` in 1: RET/halt instruction in this stage.
- `pc` out 8: current fetch PC.
- `fetch_valid` out 1: PC valid for fetch.
- `flush` out 1: squash younger pipeline registers.
- `taken` out 1: one-cycle pulse, branch resolved taken.
- `done` out 1: kernel halted.
- `taken_count` out 8: saturating count of taken branches.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `pc`=START_PC, `fetch_valid`=0. On `start`, go to RUN.
- RUN: `fetch_valid`=1. Evaluation priority when `stall`=0 is `halt` > taken branch > sequential increment.
  - `halt`: go to DONE; PC holds.
  - Taken branch: `branch_en` && (`branch_nzp` & `nzp_val`) != 0. Effects: `pc`<=`nab_out2`, `taken` pulses, `taken_count` increments, go to FLUSH, flush counter loads FLUSH_CYCLES.
  - Not-taken branch: treated as a normal instruction.
  - Otherwise, if `fetch_ready`: `pc`<=`pc`+1, modulo 256, so 8'hFF wraps to 8'h00.
- `stall`=1 in RUN: `pc` holds, `branch_en` and `halt` are ignored, and `fetch_valid` stays 1. The held instruction is evaluated exactly once, on the first unstalled cycle.
- FLUSH: `flush`=1, `fetch_valid`=0, `pc` holds the target. The counter decrements each cycle; at 1, go to RUN. `stall`, `branch_en` and `halt` are ignored.
- DONE: `done`=1, `fetch_valid`=0. On `start`, `pc`<=START_PC and go to RUN.
- `start` outside IDLE and DONE is ignored.
- `taken_count` saturates at 8'hFF. It clears only on reset, not on start.
- Mask 3'b000 is never taken. Mask 3'b111 is taken whenever `nzp_val`!=0. `nzp_val`=3'b000, the post-reset value, is never taken.

## Timing
- Reset values: state=IDLE, `pc`=START_PC, `fetch_valid`=0, `flush`=0, `taken`=0, `done`=0, `taken_count`=0.
- Reset is applied immediately and asynchronously, from any state including mid-FLUSH.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Branch latency: if the branch is evaluated in cycle N, then from N+1:
  - `pc`=target.
  - `taken`=1 for that cycle only.
  - `flush`=1 for exactly FLUSH_CYCLES cycles.
  - `fetch_valid` returns to 1 in cycle N+1+FLUSH_CYCLES.
- Increment: the PC advances in the cycle after a RUN cycle with `fetch_ready`=1 and `stall`=0.
- `halt` and taken branch in the same cycle: halt wins, no redirect, count unchanged.

## Structure
- Shared package `gpu_pkg`:
  - `pc_state_t` enum (IDLE, RUN, FLUSH, DONE).
  - `PC_W`=8.
  - NZP bit-index constants: N=2, Z=1, P=0.
- One sub-module, `flush_ctr`: 3-bit load/decrement counter with a `last` output. It drives the FLUSH-to-RUN transition.
- Condition test stays inline; it is combinational.

## Test plan
- Reset, then `start`, `fetch_ready`=1 for 4 cycles -> `pc` 00,01,02,03,04; `fetch_valid`=1.
- `nzp_val`=3'b010, `branch_nzp`=3'b010, `nab_out2`=8'h40 -> next cycle `pc`=8'h40 and `taken`=1; `flush` high 2 cycles; `fetch_valid` back to 1 on cycle 3; `taken_count`=1.
- `nzp_val`=3'b100, `branch_nzp`=3'b011 -> not taken; `pc` increments; `flush`=0.
- `stall`=1 for 3 cycles with `branch_en` held (taken) -> `pc` frozen; a single redirect and a single count increment after stall drops.
- `pc`=8'hFF with `fetch_ready`=1 -> `pc`=8'h00.
- `halt` together with a taken branch -> DONE, `done`=1, `pc` unchanged. Then `start` -> `pc`=START_PC and RUN. Assert `reset` mid-FLUSH -> all outputs at reset values immediately.
